// File: rtl/ex_cdb_unit.sv
// ---------------------------------------------------------------------------
// ex_cdb_unit
// Execution unit on the far side of the reservation-station issue port.
// Each issued RV32I integer/branch/jump op is evaluated combinationally in its
// issue cycle. The result is pushed into a small FIFO. The FIFO head is then
// broadcast on the EX common data bus until the bus arbiter grants it.
//
// Ports:
//   clk, rst             clock, asynchronous active-high reset
//   rdy                  global ready; all state freezes while low
//   clr                  pipeline flush; empties the FIFO and drops the
//                        issue presented in the same cycle
//   iRS_*                issue from the reservation station
//                        (en/op/pc/imm/rd_nick/rs1_dt/rs2_dt)
//   oRS_busy             back-pressure to the reservation station
//   oCDB_en/nick/dt      head-of-FIFO broadcast
//   iCDB_gnt             bus grant; the head pops on oCDB_en && iCDB_gnt
//   oERR_ovf             sticky flag: an issue arrived while the FIFO was full
//
// Optional feature (macro EX_BRANCH_OUT_EN):
//   When defined, each entry also stores taken/target. They are exported as
//   oROB_jump / oROB_target and qualified by oCDB_en.
//   When undefined, those ports do not exist and only nick/dt are stored.
// ---------------------------------------------------------------------------
module ex_cdb_unit #(
  parameter int DATA_W = 32,
  parameter int NICK_W = 5,
  parameter int OP_W   = 6,
  parameter int DEPTH  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rdy,
  input  logic              clr,
  input  logic              iRS_en,
  input  logic [OP_W-1:0]   iRS_op,
  input  logic [DATA_W-1:0] iRS_pc,
  input  logic [DATA_W-1:0] iRS_imm,
  input  logic [NICK_W-1:0] iRS_rd_nick,
  input  logic [DATA_W-1:0] iRS_rs1_dt,
  input  logic [DATA_W-1:0] iRS_rs2_dt,
  output logic              oRS_busy,
  output logic              oCDB_en,
  output logic [NICK_W-1:0] oCDB_nick,
  output logic [DATA_W-1:0] oCDB_dt,
  input  logic              iCDB_gnt,
  output logic              oERR_ovf
`ifdef EX_BRANCH_OUT_EN
  ,
  output logic              oROB_jump,
  output logic [DATA_W-1:0] oROB_target
`endif
);

  // Shared op encodings.
  localparam logic [OP_W-1:0] OP_LUI   = OP_W'(32'd1);
  localparam logic [OP_W-1:0] OP_AUIPC = OP_W'(32'd2);
  localparam logic [OP_W-1:0] OP_JAL   = OP_W'(32'd3);
  localparam logic [OP_W-1:0] OP_JALR  = OP_W'(32'd4);
  localparam logic [OP_W-1:0] OP_BEQ   = OP_W'(32'd5);
  localparam logic [OP_W-1:0] OP_BNE   = OP_W'(32'd6);
  localparam logic [OP_W-1:0] OP_BLT   = OP_W'(32'd7);
  localparam logic [OP_W-1:0] OP_BGE   = OP_W'(32'd8);
  localparam logic [OP_W-1:0] OP_BLTU  = OP_W'(32'd9);
  localparam logic [OP_W-1:0] OP_BGEU  = OP_W'(32'd10);
  localparam logic [OP_W-1:0] OP_ADD   = OP_W'(32'd11);
  localparam logic [OP_W-1:0] OP_SUB   = OP_W'(32'd12);
  localparam logic [OP_W-1:0] OP_AND   = OP_W'(32'd13);
  localparam logic [OP_W-1:0] OP_OR    = OP_W'(32'd14);
  localparam logic [OP_W-1:0] OP_XOR   = OP_W'(32'd15);
  localparam logic [OP_W-1:0] OP_SLT   = OP_W'(32'd16);
  localparam logic [OP_W-1:0] OP_SLTU  = OP_W'(32'd17);
  localparam logic [OP_W-1:0] OP_SLL   = OP_W'(32'd18);
  localparam logic [OP_W-1:0] OP_SRL   = OP_W'(32'd19);
  localparam logic [OP_W-1:0] OP_SRA   = OP_W'(32'd20);
  localparam logic [OP_W-1:0] OP_ADDI  = OP_W'(32'd21);
  localparam logic [OP_W-1:0] OP_ANDI  = OP_W'(32'd22);
  localparam logic [OP_W-1:0] OP_ORI   = OP_W'(32'd23);
  localparam logic [OP_W-1:0] OP_XORI  = OP_W'(32'd24);
  localparam logic [OP_W-1:0] OP_SLTI  = OP_W'(32'd25);
  localparam logic [OP_W-1:0] OP_SLTIU = OP_W'(32'd26);
  localparam logic [OP_W-1:0] OP_SLLI  = OP_W'(32'd27);
  localparam logic [OP_W-1:0] OP_SRLI  = OP_W'(32'd28);
  localparam logic [OP_W-1:0] OP_SRAI  = OP_W'(32'd29);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  // ---------------------------------------------------------------------------
  // Compute
  // ---------------------------------------------------------------------------
  logic              imm_form_s;
  logic [DATA_W-1:0] opnd2_s;
  logic [4:0]        shamt_s;
  logic [DATA_W-1:0] res_dt_s;

  // The I-type ops use the immediate as their second operand.
  always_comb begin
    case (iRS_op)
      OP_ADDI, OP_ANDI, OP_ORI, OP_XORI,
      OP_SLTI, OP_SLTIU, OP_SLLI, OP_SRLI, OP_SRAI: imm_form_s = 1'b1;
      default:                                      imm_form_s = 1'b0;
    endcase
  end

  assign opnd2_s = imm_form_s ? iRS_imm : iRS_rs2_dt;
  assign shamt_s = opnd2_s[4:0];

  // Result data for the issued op. Branches and unknown ops broadcast zero.
  always_comb begin
    res_dt_s = {DATA_W{1'b0}};
    case (iRS_op)
      OP_LUI:             res_dt_s = iRS_imm;
      OP_AUIPC:           res_dt_s = iRS_pc + iRS_imm;
      OP_JAL, OP_JALR:    res_dt_s = iRS_pc + DATA_W'(32'd4);
      OP_ADD, OP_ADDI:    res_dt_s = iRS_rs1_dt + opnd2_s;
      OP_SUB:             res_dt_s = iRS_rs1_dt - opnd2_s;
      OP_AND, OP_ANDI:    res_dt_s = iRS_rs1_dt & opnd2_s;
      OP_OR, OP_ORI:      res_dt_s = iRS_rs1_dt | opnd2_s;
      OP_XOR, OP_XORI:    res_dt_s = iRS_rs1_dt ^ opnd2_s;
      OP_SLT, OP_SLTI:    res_dt_s = {{(DATA_W-1){1'b0}}, ($signed(iRS_rs1_dt) < $signed(opnd2_s))};
      OP_SLTU, OP_SLTIU:  res_dt_s = {{(DATA_W-1){1'b0}}, (iRS_rs1_dt < opnd2_s)};
      OP_SLL, OP_SLLI:    res_dt_s = iRS_rs1_dt << shamt_s;
      OP_SRL, OP_SRLI:    res_dt_s = iRS_rs1_dt >> shamt_s;
      OP_SRA, OP_SRAI:    res_dt_s = $unsigned($signed(iRS_rs1_dt) >>> shamt_s);
      default:            res_dt_s = {DATA_W{1'b0}};
    endcase
  end

`ifdef EX_BRANCH_OUT_EN
  logic              res_taken_s;
  logic [DATA_W-1:0] res_target_s;

  // Branch/jump resolution. ALU ops and unknown ops carry no redirect.
  always_comb begin
    res_taken_s  = 1'b0;
    res_target_s = iRS_pc + iRS_imm;
    case (iRS_op)
      OP_JAL:  res_taken_s = 1'b1;
      OP_JALR: begin
        res_taken_s  = 1'b1;
        res_target_s = (iRS_rs1_dt + iRS_imm) & ~DATA_W'(32'd1);
      end
      OP_BEQ:  res_taken_s = (iRS_rs1_dt == iRS_rs2_dt);
      OP_BNE:  res_taken_s = (iRS_rs1_dt != iRS_rs2_dt);
      OP_BLT:  res_taken_s = ($signed(iRS_rs1_dt) < $signed(iRS_rs2_dt));
      OP_BGE:  res_taken_s = ($signed(iRS_rs1_dt) >= $signed(iRS_rs2_dt));
      OP_BLTU: res_taken_s = (iRS_rs1_dt < iRS_rs2_dt);
      OP_BGEU: res_taken_s = (iRS_rs1_dt >= iRS_rs2_dt);
      default: res_target_s = {DATA_W{1'b0}};
    endcase
  end
`endif

  // ---------------------------------------------------------------------------
  // Result FIFO
  // ---------------------------------------------------------------------------
  logic [NICK_W-1:0] nick_mem_r [DEPTH];
  logic [DATA_W-1:0] dt_mem_r   [DEPTH];
`ifdef EX_BRANCH_OUT_EN
  logic              taken_mem_r  [DEPTH];
  logic [DATA_W-1:0] target_mem_r [DEPTH];
`endif
  logic [PTR_W-1:0]  wr_ptr_r;
  logic [PTR_W-1:0]  rd_ptr_r;
  logic [CNT_W-1:0]  count_r;
  logic              ovf_r;

  logic              not_empty_s;
  logic              full_s;
  logic              do_clr_s;
  logic              do_pop_s;
  logic              push_req_s;
  logic              do_push_s;
  logic              ovf_set_s;

  assign not_empty_s = (count_r != CNT_W'(32'd0));
  assign full_s      = (count_r == CNT_W'(DEPTH));
  assign do_clr_s    = rdy && clr;
  assign do_pop_s    = rdy && !clr && not_empty_s && iCDB_gnt;
  assign push_req_s  = rdy && !clr && iRS_en;
  // A full FIFO still accepts an issue when the head leaves in the same cycle.
  assign do_push_s   = push_req_s && (!full_s || do_pop_s);
  assign ovf_set_s   = push_req_s && full_s && !do_pop_s;

  // Pointer, occupancy and overflow-flag state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_r <= {PTR_W{1'b0}};
      rd_ptr_r <= {PTR_W{1'b0}};
      count_r  <= {CNT_W{1'b0}};
      ovf_r    <= 1'b0;
    end else if (rdy) begin
      if (do_clr_s) begin
        wr_ptr_r <= {PTR_W{1'b0}};
        rd_ptr_r <= {PTR_W{1'b0}};
        count_r  <= {CNT_W{1'b0}};
      end else begin
        if (do_push_s) wr_ptr_r <= wr_ptr_r + PTR_W'(32'd1);
        if (do_pop_s)  rd_ptr_r <= rd_ptr_r + PTR_W'(32'd1);
        case ({do_push_s, do_pop_s})
          2'b10:   count_r <= count_r + CNT_W'(32'd1);
          2'b01:   count_r <= count_r - CNT_W'(32'd1);
          default: count_r <= count_r;
        endcase
        if (ovf_set_s) ovf_r <= 1'b1;
      end
    end
  end

  // Entry storage, written at the tail on push.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        nick_mem_r[i]   <= {NICK_W{1'b0}};
        dt_mem_r[i]     <= {DATA_W{1'b0}};
`ifdef EX_BRANCH_OUT_EN
        taken_mem_r[i]  <= 1'b0;
        target_mem_r[i] <= {DATA_W{1'b0}};
`endif
      end
    end else if (do_push_s) begin
      nick_mem_r[wr_ptr_r]   <= iRS_rd_nick;
      dt_mem_r[wr_ptr_r]     <= res_dt_s;
`ifdef EX_BRANCH_OUT_EN
      taken_mem_r[wr_ptr_r]  <= res_taken_s;
      target_mem_r[wr_ptr_r] <= res_target_s;
`endif
    end
  end

  // Head outputs are gated by occupancy so that an empty FIFO shows all zeros.
  assign oCDB_en   = not_empty_s;
  assign oCDB_nick = not_empty_s ? nick_mem_r[rd_ptr_r] : {NICK_W{1'b0}};
  assign oCDB_dt   = not_empty_s ? dt_mem_r[rd_ptr_r]   : {DATA_W{1'b0}};
  // One slot of slack covers the issue that may already be in flight.
  assign oRS_busy  = (count_r >= CNT_W'(DEPTH - 1));
  assign oERR_ovf  = ovf_r;
`ifdef EX_BRANCH_OUT_EN
  assign oROB_jump   = not_empty_s && taken_mem_r[rd_ptr_r];
  assign oROB_target = not_empty_s ? target_mem_r[rd_ptr_r] : {DATA_W{1'b0}};
`endif

endmodule

// File: tb/tb_ex_cdb_unit.sv
// ---------------------------------------------------------------------------
// tb_ex_cdb_unit
// Self-checking bench for ex_cdb_unit.
// Directed scenarios are followed by a randomized phase. Every cycle is
// compared against a queue-based reference model.
// ---------------------------------------------------------------------------
module tb_ex_cdb_unit;
  localparam int DEPTH = 4;

  typedef struct packed {
    logic [4:0]  nick;
    logic [31:0] dt;
    logic        taken;
    logic [31:0] target;
  } ent_t;

  logic        clk = 1'b0;
  logic        rst, rdy, clr, iRS_en, iCDB_gnt;
  logic [5:0]  iRS_op;
  logic [31:0] iRS_pc, iRS_imm, iRS_rs1_dt, iRS_rs2_dt;
  logic [4:0]  iRS_rd_nick;
  logic        oRS_busy, oCDB_en, oERR_ovf;
  logic [4:0]  oCDB_nick;
  logic [31:0] oCDB_dt;
`ifdef EX_BRANCH_OUT_EN
  logic        oROB_jump;
  logic [31:0] oROB_target;
`endif

  ex_cdb_unit #(.DATA_W(32), .NICK_W(5), .OP_W(6), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .rdy(rdy), .clr(clr),
    .iRS_en(iRS_en), .iRS_op(iRS_op), .iRS_pc(iRS_pc), .iRS_imm(iRS_imm),
    .iRS_rd_nick(iRS_rd_nick), .iRS_rs1_dt(iRS_rs1_dt), .iRS_rs2_dt(iRS_rs2_dt),
    .oRS_busy(oRS_busy), .oCDB_en(oCDB_en), .oCDB_nick(oCDB_nick), .oCDB_dt(oCDB_dt),
    .iCDB_gnt(iCDB_gnt), .oERR_ovf(oERR_ovf)
`ifdef EX_BRANCH_OUT_EN
    , .oROB_jump(oROB_jump), .oROB_target(oROB_target)
`endif
  );

  always #5 clk = ~clk;

  int   n_checks = 0;
  int   n_errors = 0;
  ent_t q[$];
  logic ovf_m = 1'b0;

  // Single comparison point: counts and reports.
  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference ALU, by operation kind: 0 add, 1 sub, 2 and, 3 or, 4 xor,
  // 5 slt, 6 sltu, 7 sll, 8 srl, 9 sra.
  function automatic logic [31:0] alu(input int kind, input logic [31:0] a, input logic [31:0] b);
    int s;
    s = int'(b[4:0]);
    case (kind)
      0: return a + b;
      1: return a - b;
      2: return a & b;
      3: return a | b;
      4: return a ^ b;
      5: return ((a ^ 32'h8000_0000) < (b ^ 32'h8000_0000)) ? 32'd1 : 32'd0;
      6: return (a < b) ? 32'd1 : 32'd0;
      7: return a << s;
      8: return a >> s;
      9: return (a >> s) | (a[31] ? ~(32'hFFFF_FFFF >> s) : 32'd0);
      default: return 32'd0;
    endcase
  endfunction

  function automatic ent_t model_exec(input logic [5:0] op, input logic [31:0] pc, input logic [31:0] imm,
                                      input logic [31:0] a, input logic [31:0] b, input logic [4:0] nick);
    ent_t e;
    int   o;
    e = '0;
    e.nick = nick;
    o = int'(op);
    if (o == 1) e.dt = imm;
    else if (o == 2) e.dt = pc + imm;
    else if (o == 3 || o == 4) begin
      e.dt = pc + 32'd4;
      e.taken = 1'b1;
      e.target = (o == 4) ? ((a + imm) & 32'hFFFF_FFFE) : (pc + imm);
    end else if (o >= 5 && o <= 10) begin
      e.target = pc + imm;
      case (o)
        5:  e.taken = (a == b);
        6:  e.taken = (a != b);
        7:  e.taken = alu(5, a, b)[0];
        8:  e.taken = !alu(5, a, b)[0];
        9:  e.taken = (a < b);
        default: e.taken = (a >= b);
      endcase
    end else if (o >= 11 && o <= 20) e.dt = alu(o - 11, a, b);
    else if (o == 21) e.dt = alu(0, a, imm);
    else if (o >= 22 && o <= 29) e.dt = alu(o - 20, a, imm);
    return e;
  endfunction

  task automatic model_update();
    ent_t e;
    bit   pop, full;
    if (rdy) begin
      if (clr) q.delete();
      else begin
        pop  = (q.size() != 0) && iCDB_gnt;
        full = (q.size() == DEPTH);
        e = model_exec(iRS_op, iRS_pc, iRS_imm, iRS_rs1_dt, iRS_rs2_dt, iRS_rd_nick);
        if (pop) void'(q.pop_front());
        if (iRS_en) begin
          if (full && !pop) ovf_m = 1'b1;
          else q.push_back(e);
        end
      end
    end
  endtask

  task automatic check_all();
    ent_t h;
    h = (q.size() != 0) ? q[0] : '0;
    check("cdb_en",   {63'd0, oCDB_en}, {63'd0, (q.size() != 0)});
    check("cdb_nick", {59'd0, oCDB_nick}, {59'd0, h.nick});
    check("cdb_dt",   {32'd0, oCDB_dt}, {32'd0, h.dt});
    check("rs_busy",  {63'd0, oRS_busy}, {63'd0, (q.size() >= DEPTH - 1)});
    check("err_ovf",  {63'd0, oERR_ovf}, {63'd0, ovf_m});
`ifdef EX_BRANCH_OUT_EN
    check("rob_jump",   {63'd0, oROB_jump}, {63'd0, h.taken});
    check("rob_target", {32'd0, oROB_target}, {32'd0, h.target});
`endif
  endtask

  // One clock: model follows the posedge, outputs checked at the negedge.
  task automatic tick();
    @(posedge clk);
    model_update();
    @(negedge clk);
    check_all();
  endtask

  task automatic idle();
    iRS_en = 1'b0; clr = 1'b0; rdy = 1'b1;
  endtask

  task automatic issue(input logic [5:0] op, input logic [31:0] pc, input logic [31:0] imm,
                       input logic [4:0] nick, input logic [31:0] a, input logic [31:0] b);
    iRS_en = 1'b1; iRS_op = op; iRS_pc = pc; iRS_imm = imm;
    iRS_rd_nick = nick; iRS_rs1_dt = a; iRS_rs2_dt = b;
  endtask

  task automatic do_reset();
    idle();
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    q.delete();
    ovf_m = 1'b0;
    check_all();
  endtask

  initial begin
    rst = 1'b1; rdy = 1'b1; clr = 1'b0; iRS_en = 1'b0; iCDB_gnt = 1'b0;
    iRS_op = 6'd0; iRS_pc = 32'd0; iRS_imm = 32'd0; iRS_rd_nick = 5'd0;
    iRS_rs1_dt = 32'd0; iRS_rs2_dt = 32'd0;
    do_reset();
    check("rst_en", {63'd0, oCDB_en}, 64'd0);
    check("rst_dt", {32'd0, oCDB_dt}, 64'd0);

    // ADDI with single-cycle latency, then drain.
    iCDB_gnt = 1'b1;
    issue(6'd21, 32'd0, 32'hFFFF_FFFE, 5'd3, 32'd5, 32'd0);
    tick();
    check("addi_en", {63'd0, oCDB_en}, 64'd1);
    check("addi_nick", {59'd0, oCDB_nick}, 64'd3);
    check("addi_dt", {32'd0, oCDB_dt}, 64'd3);
    idle();
    tick();
    check("addi_drain", {63'd0, oCDB_en}, 64'd0);

    // Busy threshold, then in-order drain.
    iCDB_gnt = 1'b0;
    issue(6'd11, 32'd0, 32'd0, 5'd1, 32'd1, 32'd2); tick();
    issue(6'd12, 32'd0, 32'd0, 5'd2, 32'd1, 32'd2); tick();
    check("busy_cnt2", {63'd0, oRS_busy}, 64'd0);
    issue(6'd15, 32'd0, 32'd0, 5'd4, 32'd6, 32'd3); tick();
    check("busy_cnt3", {63'd0, oRS_busy}, 64'd1);
    idle(); iCDB_gnt = 1'b1; tick();
    check("busy_drop", {63'd0, oRS_busy}, 64'd0);
    check("order_2nd", {59'd0, oCDB_nick}, 64'd2);
    tick(); tick();

    // Overflow on the fifth issue into a stalled FIFO.
    iCDB_gnt = 1'b0;
    for (int i = 0; i < 5; i++) begin
      issue(6'd21, 32'd0, i, 5'(i + 8), 32'd100, 32'd0);
      tick();
    end
    check("ovf_set", {63'd0, oERR_ovf}, 64'd1);
    check("ovf_head", {59'd0, oCDB_nick}, 64'd8);
    idle(); iCDB_gnt = 1'b1;
    repeat (4) tick();
    check("ovf_sticky", {63'd0, oERR_ovf}, 64'd1);
    check("ovf_drained", {63'd0, oCDB_en}, 64'd0);

    // Signed vs unsigned branch compare.
    iCDB_gnt = 1'b0;
    issue(6'd7, 32'h100, 32'h20, 5'd4, 32'hFFFF_FFFF, 32'd1); tick();
    check("blt_dt", {32'd0, oCDB_dt}, 64'd0);
`ifdef EX_BRANCH_OUT_EN
    check("blt_jump", {63'd0, oROB_jump}, 64'd1);
    check("blt_target", {32'd0, oROB_target}, 64'h120);
`endif
    issue(6'd9, 32'h100, 32'h20, 5'd5, 32'hFFFF_FFFF, 32'd1); tick();
    idle(); iCDB_gnt = 1'b1; tick();
    check("bltu_nick", {59'd0, oCDB_nick}, 64'd5);
`ifdef EX_BRANCH_OUT_EN
    check("bltu_jump", {63'd0, oROB_jump}, 64'd0);
`endif
    tick();

    // Flush with a simultaneous issue, then SRA.
    iCDB_gnt = 1'b0;
    issue(6'd11, 32'd0, 32'd0, 5'd1, 32'd1, 32'd1); tick();
    issue(6'd11, 32'd0, 32'd0, 5'd2, 32'd2, 32'd2); tick();
    issue(6'd11, 32'd0, 32'd0, 5'd3, 32'd3, 32'd3); clr = 1'b1; tick();
    check("clr_empty", {63'd0, oCDB_en}, 64'd0);
    idle();
    issue(6'd20, 32'd0, 32'd0, 5'd7, 32'h8000_0000, 32'h21); tick();
    check("sra_dt", {32'd0, oCDB_dt}, 64'hC000_0000);
    idle(); iCDB_gnt = 1'b1; tick();

    // rdy low freezes everything.
    iCDB_gnt = 1'b0;
    issue(6'd21, 32'd0, 32'd1, 5'd9, 32'd41, 32'd0); tick();
    iCDB_gnt = 1'b1;
    issue(6'd11, 32'd0, 32'd0, 5'd10, 32'd1, 32'd1);
    rdy = 1'b0;
    repeat (3) begin
      tick();
      check("frz_nick", {59'd0, oCDB_nick}, 64'd9);
      check("frz_dt", {32'd0, oCDB_dt}, 64'd42);
    end
    idle(); tick();
    check("frz_resume", {63'd0, oCDB_en}, 64'd0);

    // Randomized phase.
    for (int blk = 0; blk < 3; blk++) begin
      do_reset();
      for (int c = 0; c < 1000; c++) begin
        rdy      = ($urandom_range(0, 9) != 0);
        clr      = ($urandom_range(0, 24) == 0);
        iCDB_gnt = ($urandom_range(0, 1) == 1);
        iRS_en   = ($urandom_range(0, 9) < 6);
        if (oRS_busy && (blk != 2) && ($urandom_range(0, 3) != 0)) iRS_en = 1'b0;
        iRS_op      = 6'($urandom_range(0, 31));
        iRS_pc      = $urandom & 32'hFFFF_FFFC;
        iRS_imm     = ($urandom_range(0, 1) == 1) ? $urandom : 32'($signed($urandom_range(0, 63)) - 32);
        iRS_rd_nick = 5'($urandom_range(0, 31));
        iRS_rs1_dt  = $urandom;
        iRS_rs2_dt  = ($urandom_range(0, 3) == 0) ? iRS_rs1_dt : $urandom;
        tick();
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/ex_cdb_unit.md
Name: ex_cdb_unit

Overview:
- Execution-side consumer of the reservation station issue port; the other end of the RS→EX interface.
- Computes RV32I integer/branch/jump results for each issued instruction.
- Buffers results in a small FIFO and drives them onto the EX common data bus (en/nick/dt) that the reservation station and ROB snoop.
- Exerts back-pressure on the RS through a busy flag.

Parameters:
DATA_W, 32, width of operands, immediates, pc and results
NICK_W, 5, ROB nickname width
OP_W, 6, op code width; encodings are the shared op macros in config.v
DEPTH, 4, result FIFO entries (power of two, >=2)

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
rdy  in  1  global ready; when low all state freezes
clr  in  1  pipeline flush (misprediction)
iRS_en  in  1  issue valid from reservation station
iRS_op  in  OP_W  operation
iRS_pc  in  DATA_W  instruction pc
iRS_imm  in  DATA_W  sign-extended immediate
iRS_rd_nick  in  NICK_W  destination nickname
iRS_rs1_dt  in  DATA_W  operand 1
iRS_rs2_dt  in  DATA_W  operand 2
oRS_busy  out  1  RS must not issue while high
oCDB_en  out  1  broadcast valid (FIFO head present)
oCDB_nick  out  NICK_W  head nickname
oCDB_dt  out  DATA_W  head result value
iCDB_gnt  in  1  bus grant; head pops when oCDB_en && iCDB_gnt
oERR_ovf  out  1  sticky overflow flag

Behaviour:
- Reset (async, rst=1): FIFO empty, pointers and count 0, all outputs 0 (oCDB_en=0, oCDB_nick=0, oCDB_dt=0, oRS_busy=0, oERR_ovf=0).
- rdy=0: no push, no pop, no flag change. Outputs hold.
- Compute is combinational in the issue cycle:
  - LUI: imm.
  - AUIPC: pc+imm.
  - JAL/JALR: dt=pc+4; target pc+imm, or (rs1+imm)&~1 for JALR; taken=1.
  - BEQ/BNE/BLT/BGE/BLTU/BGEU: dt=0; taken per signed/unsigned compare; target pc+imm.
  - ADD/ADDI, SUB, AND/ANDI, OR/ORI, XOR/XORI, SLT(I), SLTU(I), SLL(I)/SRL(I)/SRA(I): second operand is rs2 for R-type, imm for I-type; shift amount is operand[4:0].
  - All arithmetic is modulo 2^DATA_W.
  - Unknown op: dt=0, taken=0.
- Push: at posedge when rdy && !clr && iRS_en, entry {nick, dt, taken, target} is written at the tail. The result is visible on oCDB in cycle N+1 at the earliest (1-cycle latency when FIFO is empty).
- oCDB_* reflect the FIFO head combinationally from registered storage. oCDB_en = (count != 0).
- Pop: at posedge when rdy && !clr && oCDB_en && iCDB_gnt, the head advances.
- Simultaneous push and pop: count unchanged; a push into an empty FIFO cannot pop in the same cycle.
- Pointers wrap modulo DEPTH; count ranges 0..DEPTH.
- oRS_busy = (count >= DEPTH-1), combinational. This leaves one slot of slack for the issue already in flight.
- Push while full and no pop: entry dropped, oERR_ovf set to 1 and held until rst.
- clr (rdy=1): FIFO emptied at that posedge (count=0, pointers 0). An issue presented in the same cycle is discarded. oERR_ovf is unaffected.
- clr has priority over push/pop; rst has priority over everything.

Optional Feature:
EX_BRANCH_OUT_EN:
- Defined: adds outputs oROB_jump (1) and oROB_target (DATA_W), driven from the head entry's taken/target, qualified by oCDB_en; both reset to 0.
- Undefined: no such ports; taken/target are not stored and the FIFO is DATA_W+NICK_W wide; branches broadcast dt=0 only.

Test Plan:
- Reset then issue ADDI nick=3, rs1=5, imm=-2 with gnt=1 -> next cycle oCDB_en=1, nick=3, dt=3; following cycle oCDB_en=0.
- gnt=0, issue 3 ops back-to-back (DEPTH=4) -> oRS_busy rises once count=3. Raise gnt -> entries pop in issue order, one per cycle, and busy drops when count=2.
- Hold gnt=0, force 5 issues -> fifth issue dropped, oERR_ovf=1 sticky, the four stored results still drain in order.
- BLT rs1=0xFFFFFFFF, rs2=1, pc=0x100, imm=0x20 with EX_BRANCH_OUT_EN -> oROB_jump=1, oROB_target=0x120, dt=0. BLTU with the same operands -> jump=0.
- Fill 2 entries, assert clr together with a new issue -> next cycle oCDB_en=0 and count=0. Later issue SRA rs1=0x80000000, rs2=0x21 -> dt=0xC0000000.
- FIFO holds 1 entry, rdy=0 for 3 cycles with gnt=1 and issue asserted -> no pop, no push, outputs unchanged. After rdy=1 the normal pop resumes.
